// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bundle between the CPU control logic
// and the bit-serial adder sequencer.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: time-shares one full-adder cell to add two WIDTH-bit
// operands LSB first, one bit per clock, behind a start/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // One-hot so ready/busy/done come straight off state flops.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Shared full-adder cell working on the current LSBs and the carry flop.
    assign fa_s  = sh_a[0] ^ sh_b[0] ^ carry;
    assign fa_co = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            work   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            work  <= '0;
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            work  <= {fa_s, work[WIDTH-1:1]};
            carry <= fa_co;
            if (last_bit) begin
                // Carry into the MSB is the carry flop on this final bit.
                sum_q  <= {fa_s, work[WIDTH-1:1]};
                cout_q <= fa_co;
                ovf_q  <= fa_co ^ carry;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ready    = state[0];
    assign bus.busy     = state[1];
    assign bus.done     = state[2];
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16
// against an arithmetic reference model.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    // Expected {overflow, cout, sum} currently held by each DUT.
    logic [33:0] exp8  = '0;
    logic [33:0] exp16 = '0;

    logic [31:0] oa [30];
    logic [31:0] ob [30];
    logic        oc [30];

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8))  bus8 ();
    serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();

    serial_adder_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_adder_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
        logic [63:0] full;
        logic [63:0] mask;
        logic [31:0] s;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        full = 64'(a) + 64'(b) + 64'(cin);
        s    = 32'(full & mask);
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    function automatic logic [63:0] st(input logic r, input logic bz, input logic d, input logic [33:0] res);
        return {27'd0, r, bz, d, res[33], res[32], res[31:0]};
    endfunction

    function automatic logic [63:0] sample(input bit s16);
        if (s16)
            return {27'd0, bus16.ready, bus16.busy, bus16.done, bus16.overflow, bus16.cout, 32'(bus16.sum)};
        return {27'd0, bus8.ready, bus8.busy, bus8.done, bus8.overflow, bus8.cout, 32'(bus8.sum)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s16, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
        if (s16) begin
            bus16.start = s; bus16.a = 16'(a); bus16.b = 16'(b); bus16.cin = cin;
        end else begin
            bus8.start = s;  bus8.a = 8'(a);   bus8.b = 8'(b);   bus8.cin = cin;
        end
    endtask

    // One full operation from IDLE; returns at #1 after the edge that re-enters IDLE.
    task automatic run_op(input bit s16, input logic [31:0] a_in, input logic [31:0] b_in, input logic cin);
        int          w;
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [33:0] prev;
        logic [33:0] r;
        w    = s16 ? 16 : 8;
        mask = s16 ? 32'h0000_FFFF : 32'h0000_00FF;
        a    = a_in & mask;
        b    = b_in & mask;
        prev = s16 ? exp16 : exp8;
        r    = ref_add(w, a, b, cin);
        chk("pre_ready", sample(s16), st(1'b1, 1'b0, 1'b0, prev));
        drive(s16, 1'b1, a, b, cin);
        @(posedge clk); #1;
        drive(s16, 1'b0, $urandom, $urandom, 1'($urandom));
        for (int k = 0; k < w; k++) begin
            chk("run_hold", sample(s16), st(1'b0, 1'b1, 1'b0, prev));
            @(posedge clk); #1;
        end
        chk("done_result", sample(s16), st(1'b0, 1'b0, 1'b1, r));
        @(posedge clk); #1;
        chk("back_idle", sample(s16), st(1'b1, 1'b0, 1'b0, r));
        if (s16) exp16 = r;
        else     exp8  = r;
    endtask

    initial begin
        int ph;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("reset8",  sample(1'b0), st(1'b1, 1'b0, 1'b0, 34'd0));
        chk("reset16", sample(1'b1), st(1'b1, 1'b0, 1'b0, 34'd0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_hold", sample(1'b0), st(1'b1, 1'b0, 1'b0, 34'd0));
        end

        // Directed arithmetic cases.
        run_op(1'b0, 32'h5A, 32'h33, 1'b0);
        chk("dir_5a33", sample(1'b0), st(1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8D}));
        run_op(1'b0, 32'hFF, 32'h01, 1'b0);
        chk("dir_ff01", sample(1'b0), st(1'b1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00}));
        run_op(1'b0, 32'h7F, 32'h00, 1'b1);
        chk("dir_7f00c", sample(1'b0), st(1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80}));

        // Asynchronous reset between edges clears results at once.
        #2 rst = 1'b1;
        #1 chk("async_rst", sample(1'b0), st(1'b1, 1'b0, 1'b0, 34'd0));
        exp8 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(1'b0, 32'hC3, 32'h5E, 1'b1);

        // start held high with operands changing every cycle: accepts at E0, E10, E20.
        for (int c = 0; c < 30; c++) begin
            oa[c] = $urandom & 32'hFF;
            ob[c] = $urandom & 32'hFF;
            oc[c] = 1'($urandom);
            drive(1'b0, 1'b1, oa[c], ob[c], oc[c]);
            @(posedge clk); #1;
            ph = c % 10;
            if (ph == 8) exp8 = ref_add(8, oa[c-8], ob[c-8], oc[c-8]);
            chk("b2b", sample(1'b0), st(ph == 9, ph <= 7, ph == 8, exp8));
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        chk("b2b_stop", sample(1'b0), st(1'b1, 1'b0, 1'b0, exp8));

        // Reset during the 4th RUN cycle aborts without a done pulse.
        drive(1'b0, 1'b1, 32'h11, 32'h22, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_rst", sample(1'b0), st(1'b1, 1'b0, 1'b0, 34'd0));
        exp8  = '0;
        exp16 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort_quiet", sample(1'b0), st(1'b1, 1'b0, 1'b0, 34'd0));
        end
        run_op(1'b0, 32'h10, 32'h20, 1'b0);
        chk("after_abort", sample(1'b0), st(1'b1, 1'b0, 1'b0, {1'b0, 1'b0, 32'h30}));

        // Randomized operations at both widths with random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            run_op(1'b0, $urandom, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 1000; i++) begin
            run_op(1'b1, $urandom, $urandom, 1'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        run_op(1'b1, 32'h7FFF, 32'h0001, 1'b0);
        chk("w16_ovf", sample(1'b1), st(1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition sequencer that time-shares a single `full_adder` cell to add two WIDTH-bit operands, one bit per clock, LSB first. It owns the operand shift registers, the carry flop, the bit counter and a start/done handshake. It sits between the CPU control logic and the adder cell and replaces a WIDTH-bit ripple adder where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  request; sampled only when `ready`=1.
- `a`  in  WIDTH  operand A; sampled on the accept edge only.
- `b`  in  WIDTH  operand B; sampled on the accept edge only.
- `cin`  in  1  carry-in; sampled on the accept edge only.
- `ready`  out  1  high only in IDLE; a request is accepted this cycle if `start`=1.
- `busy`  out  1  high only in RUN.
- `done`  out  1  single-cycle pulse, high only in DONE.
- `sum`  out  WIDTH  result of the last completed operation.
- `cout`  out  1  carry out of bit WIDTH-1 of the last completed operation.
- `overflow`  out  1  signed overflow of the last completed operation.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: `ready`=1. Edge with `start`=1: load `a`, `b` into shift registers, carry flop <= `cin`, bit counter <= 0, clear working sum register, go to RUN. `start`=0: stay.
- RUN: one `full_adder` instance, inputs = shift-reg A bit 0, shift-reg B bit 0, carry flop. Each edge: A, B shift right by 1; adder sum bit shifted into MSB of working sum register (shift right); carry flop <= adder carry out; counter +1. On the edge where counter = WIDTH-1 (last bit): also load `sum` <= completed working value, `cout` <= adder carry out, `overflow` <= adder carry out XOR carry flop (carry into MSB); go to DONE.
- DONE: `done`=1 for exactly one cycle; unconditionally go to IDLE on next edge.
- `start` in RUN or DONE is ignored; no queuing.
- `sum`, `cout`, `overflow` hold their value from the last completed operation through IDLE, RUN and DONE; they change only on the RUN->DONE edge.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, unsigned, exact; `overflow` = signed two's-complement overflow of the same addition.
- Counter width: ceil(log2(WIDTH)) bits; no wrap occurs within an operation.
- Reset (any time, including mid-RUN): state IDLE, counter 0, carry 0, shift registers 0, `sum`=0, `cout`=0, `overflow`=0, `done`=0, `busy`=0, `ready`=1. Aborted operation produces no `done` pulse and no output update.

## Timing
- Accept edge E0 (IDLE, `start`=1). Bits 0..WIDTH-1 processed on edges E1..E(WIDTH). `done`=1 in the cycle between E(WIDTH) and E(WIDTH+1); results valid from E(WIDTH) onward.
- Latency: `done` rises WIDTH cycles after the accept edge. Throughput: one operation per WIDTH+2 cycles (next accept earliest at E(WIDTH+2) with `start` held high).
- `ready`, `busy`, `done` are registered-state decodes: mutually exclusive, exactly one high at all times outside reset.
- Operand inputs may change freely after E0 without effect.

## Test plan
- Reset: assert `rst` asynchronously between edges -> outputs zero immediately, `ready`=1, `busy`=0, `done`=0; hold `start`=0 for 10 cycles -> no state change.
- WIDTH=8, `a`=0x5A, `b`=0x33, `cin`=0 -> `busy` for 8 cycles, `done` pulse 1 cycle, `sum`=0x8D, `cout`=0, `overflow`=1.
- `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1, `overflow`=0; `a`=0x7F, `b`=0x00, `cin`=1 -> `sum`=0x80, `cout`=0, `overflow`=1.
- `start` held high continuously with operands changing every cycle -> accepts only at E0, E10, E20 (WIDTH=8); each result matches operands present at its accept edge; `sum` stable between updates.
- Reset asserted on 4th RUN cycle -> no `done` pulse, `sum`=0, `cout`=0; new op `a`=0x10, `b`=0x20 after release -> `sum`=0x30.
- Random 1000 ops, WIDTH=8 and WIDTH=16, random `cin` -> {`cout`,`sum`} and `overflow` match reference model; `done` exactly WIDTH cycles after every accept.
